// File: rtl/kern_th_edge_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : kern_th_edge_pipe_if
//  Description : Stream bundle for the threshold-edge kernel.
//                Input side : s_valid/s_ready handshake, s_block {up,right,
//                             down,left} (left in LSBs), s_last frame marker.
//                Output side: m_valid/m_ready handshake, m_thdx/m_thdy edge
//                             flags, m_last frame marker.
//                Modports   : slave  = kernel side (consumes s_*, produces m_*)
//                             master = neighbourhood builder / edge-map writer
//                                      side (produces s_*, consumes m_*)
//  Revision    : 1.0 - initial release
// ============================================================================
interface kern_th_edge_pipe_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                     s_valid;
    logic                     s_ready;
    logic [4*PIXEL_WIDTH-1:0] s_block;
    logic                     s_last;

    logic                     m_valid;
    logic                     m_ready;
    logic                     m_thdx;
    logic                     m_thdy;
    logic                     m_last;

    modport slave (
        input  s_valid, s_block, s_last, m_ready,
        output s_ready, m_valid, m_thdx, m_thdy, m_last
    );

    modport master (
        output s_valid, s_block, s_last, m_ready,
        input  s_ready, m_valid, m_thdx, m_thdy, m_last
    );
endinterface
`default_nettype wire

// File: rtl/kern_th_edge_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : kern_th_edge_pipe
//  Description : Streaming threshold-edge kernel. Each accepted neighbour
//                block produces gradients dx = left - right, dy = down - up
//                (stage 1), which are compared against per-beat thresholds
//                in signed or absolute mode (stage 2). Output transfers that
//                carry an edge are counted per frame (saturating).
//  Ports       : clock        - single rising-edge clock
//                nReset       - asynchronous active-low reset
//                clear        - synchronous pipeline flush / counter zero
//                thr_x, thr_y - thresholds for dx, dy
//                mode_abs     - 0: signed gradients, 1: absolute gradients
//                bus          - stream interface (slave modport)
//                frame_edges  - edge count of last completed frame
//                frame_done   - one-cycle pulse when frame_edges updates
//  Revision    : 1.0 - initial release
// ============================================================================
module kern_th_edge_pipe #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 20
) (
    input  wire logic                   clock,
    input  wire logic                   nReset,
    input  wire logic                   clear,
    input  wire logic [PIXEL_WIDTH-1:0] thr_x,
    input  wire logic [PIXEL_WIDTH-1:0] thr_y,
    input  wire logic                   mode_abs,
    kern_th_edge_pipe_if.slave          bus,
    output logic      [CNT_WIDTH-1:0]   frame_edges,
    output logic                        frame_done
);

    localparam int PW = PIXEL_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Stage 1 registers: gradients plus the configuration of this beat
    // ------------------------------------------------------------------
    logic                 r_v1;
    logic        [PW:0]   r_dx;
    logic        [PW:0]   r_dy;
    logic        [PW-1:0] r_thr_x;
    logic        [PW-1:0] r_thr_y;
    logic                 r_abs1;
    logic                 r_last1;

    // Stage 2 registers drive the output stream directly
    logic                 r_v2;
    logic                 r_thdx;
    logic                 r_thdy;
    logic                 r_last2;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_frame_edges;
    logic                 r_frame_done;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_adv2;
    logic w_s_ready;
    logic w_s_fire;
    logic w_m_fire;

    assign w_adv2    = !r_v2 || bus.m_ready;
    assign w_s_ready = !clear && (!r_v1 || w_adv2);
    assign w_s_fire  = bus.s_valid && w_s_ready;
    assign w_m_fire  = r_v2 && bus.m_ready;

    // ------------------------------------------------------------------
    // Stage 1 datapath. Zero-extending both operands by one bit keeps the
    // difference exact: it always lies within the PW+1 bit signed range.
    // ------------------------------------------------------------------
    logic [PW:0] w_left;
    logic [PW:0] w_right;
    logic [PW:0] w_down;
    logic [PW:0] w_up;
    logic [PW:0] w_dx;
    logic [PW:0] w_dy;

    assign w_left  = {1'b0, bus.s_block[0*PW +: PW]};
    assign w_down  = {1'b0, bus.s_block[1*PW +: PW]};
    assign w_right = {1'b0, bus.s_block[2*PW +: PW]};
    assign w_up    = {1'b0, bus.s_block[3*PW +: PW]};
    assign w_dx    = w_left - w_right;
    assign w_dy    = w_down - w_up;

    // ------------------------------------------------------------------
    // Stage 2 datapath. The magnitude of a PW+1 bit gradient never exceeds
    // 2^PW - 1, so it stays non-negative in PW+1 bit signed form and one
    // signed comparator against the zero-extended threshold serves both
    // modes.
    // ------------------------------------------------------------------
    logic [PW:0] w_opx;
    logic [PW:0] w_opy;
    logic        w_thdx;
    logic        w_thdy;

    assign w_opx  = (r_abs1 && r_dx[PW]) ? (~r_dx + 1'b1) : r_dx;
    assign w_opy  = (r_abs1 && r_dy[PW]) ? (~r_dy + 1'b1) : r_dy;
    assign w_thdx = $signed(w_opx) >= $signed({1'b0, r_thr_x});
    assign w_thdy = $signed(w_opy) >= $signed({1'b0, r_thr_y});

    // Edge counter increment, saturating at all-ones
    logic                 w_hit;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    assign w_hit      = r_thdx || r_thdy;
    assign w_cnt_next = (w_hit && (r_cnt != c_CNT_MAX)) ? (r_cnt + c_CNT_ONE) : r_cnt;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_v1          <= 1'b0;
            r_dx          <= '0;
            r_dy          <= '0;
            r_thr_x       <= '0;
            r_thr_y       <= '0;
            r_abs1        <= 1'b0;
            r_last1       <= 1'b0;
            r_v2          <= 1'b0;
            r_thdx        <= 1'b0;
            r_thdy        <= 1'b0;
            r_last2       <= 1'b0;
            r_cnt         <= '0;
            r_frame_edges <= '0;
            r_frame_done  <= 1'b0;
        end else if (clear) begin
            // Flush wins over any transfer presented in the same cycle;
            // the last completed frame count is kept.
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_s_fire) begin
                r_v1    <= 1'b1;
                r_dx    <= w_dx;
                r_dy    <= w_dy;
                r_thr_x <= thr_x;
                r_thr_y <= thr_y;
                r_abs1  <= mode_abs;
                r_last1 <= bus.s_last;
            end else if (w_adv2) begin
                r_v1 <= 1'b0;
            end

            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_thdx  <= w_thdx;
                    r_thdy  <= w_thdy;
                    r_last2 <= r_last1;
                end
            end

            if (w_m_fire) begin
                if (r_last2) begin
                    r_frame_edges <= w_cnt_next;
                    r_frame_done  <= 1'b1;
                    r_cnt         <= '0;
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_v2;
    assign bus.m_thdx  = r_thdx;
    assign bus.m_thdy  = r_thdy;
    assign bus.m_last  = r_last2;
    assign frame_edges = r_frame_edges;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_kern_th_edge_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kern_th_edge_pipe
//  Description : Directed self-checking bench for kern_th_edge_pipe.
//                Counter width is reduced to 3 bits so saturation is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kern_th_edge_pipe;

    localparam int PW = 8;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          nReset = 1'b0;
    logic          clear = 1'b0;
    logic [PW-1:0] thr_x = 8'd33;
    logic [PW-1:0] thr_y = 8'd32;
    logic          mode_abs = 1'b0;
    logic [CW-1:0] frame_edges;
    logic          frame_done;

    always #5 clock = ~clock;

    kern_th_edge_pipe_if #(.PIXEL_WIDTH(PW)) bus ();

    kern_th_edge_pipe #(
        .PIXEL_WIDTH (PW),
        .CNT_WIDTH   (CW)
    ) u_dut (
        .clock       (clock),
        .nReset      (nReset),
        .clear       (clear),
        .thr_x       (thr_x),
        .thr_y       (thr_y),
        .mode_abs    (mode_abs),
        .bus         (bus),
        .frame_edges (frame_edges),
        .frame_done  (frame_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // m_ready: fixed level or toggling every cycle, updated at posedge+2
    logic tgl_en    = 1'b0;
    logic rdy_level = 1'b1;
    always @(posedge clock) begin
        #2;
        bus.m_ready = tgl_en ? ~bus.m_ready : rdy_level;
    end

    // Output monitor: records transfers {thdx,thdy,last}, frame_done pulses,
    // and checks that a stalled output does not change.
    logic [2:0]    rec[$];
    int            fd_cnt = 0;
    logic [CW-1:0] fd_val = '0;
    logic          ph = 1'b0;
    logic          pclr = 1'b0;
    logic [3:0]    pv = '0;

    always @(negedge clock) begin
        if (!nReset) begin
            ph = 1'b0;
        end else begin
            if (ph && !pclr)
                chk("hold", 32'({bus.m_valid, bus.m_thdx, bus.m_thdy, bus.m_last}), 32'(pv));
            if (bus.m_valid && bus.m_ready && !clear)
                rec.push_back({bus.m_thdx, bus.m_thdy, bus.m_last});
            if (frame_done) begin
                fd_cnt++;
                fd_val = frame_edges;
            end
            ph   = bus.m_valid && !bus.m_ready;
            pv   = {bus.m_valid, bus.m_thdx, bus.m_thdy, bus.m_last};
            pclr = clear;
        end
    end

    // Present one block and hold it until accepted; returns at posedge+1
    task automatic send(input logic [7:0] up, input logic [7:0] rt,
                        input logic [7:0] dn, input logic [7:0] lf, input logic last);
        logic acc;
        int   n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_block = {up, rt, dn, lf};
        bus.s_last  = last;
        forever begin
            @(negedge clock);
            acc = bus.s_ready;
            @(posedge clock);
            #1;
            if (acc) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_rec(input string tag, input int n);
        for (int k = 0; k < 300 && rec.size() < n; k++) @(negedge clock);
        repeat (3) @(negedge clock);
        chk(tag, 32'(rec.size()), 32'(n));
    endtask

    task automatic chk_rec(input string tag, input int idx, input logic [2:0] exp);
        logic [2:0] got;
        got = (idx < rec.size()) ? rec[idx] : 3'bxxx;
        chk($sformatf("%s[%0d]", tag, idx), 32'(got), 32'(exp));
    endtask

    task automatic sync_drive();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] t1v [7] = '{8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd32, 8'd33};
    logic [2:0] t1e [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b110};
    logic [7:0] t4v [8] = '{8'd40, 8'd0, 8'd32, 8'd33, 8'd5, 8'd100, 8'd31, 8'd32};
    logic [2:0] t4e [8] = '{3'b110, 3'b000, 3'b010, 3'b110, 3'b000, 3'b110, 3'b000, 3'b010};
    logic [7:0] t5v [5] = '{8'd40, 8'd0, 8'd40, 8'd5, 8'd40};

    initial begin
        bus.s_valid = 1'b0;
        bus.s_block = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        // ---------------- reset state
        repeat (3) @(posedge clock);
        #1 nReset = 1'b1;
        @(negedge clock);
        chk("rst_s_ready",     32'(bus.s_ready), 32'd1);
        chk("rst_m_valid",     32'(bus.m_valid), 32'd0);
        chk("rst_m_thd",       32'({bus.m_thdx, bus.m_thdy, bus.m_last}), 32'd0);
        chk("rst_frame_edges", 32'(frame_edges), 32'd0);
        chk("rst_frame_done",  32'(frame_done),  32'd0);
        sync_drive();

        // ---------------- legacy thresholds, signed mode
        for (int i = 0; i < 7; i++) send(8'd0, 8'd0, t1v[i], t1v[i], 1'b0);
        wait_rec("t1_count", 7);
        for (int i = 0; i < 7; i++) chk_rec("t1", i, t1e[i]);
        rec.delete();
        sync_drive();

        // ---------------- abs vs signed, thr=32
        thr_x = 8'd32; thr_y = 8'd32; mode_abs = 1'b1;
        send(8'd200, 8'd40, 8'd168, 8'd0, 1'b0);
        mode_abs = 1'b0;
        send(8'd200, 8'd40, 8'd168, 8'd0, 1'b0);
        // extremes, signed thr=32
        send(8'd255, 8'd0, 8'd0, 8'd255, 1'b0);
        send(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        // abs mode at the threshold boundaries
        thr_x = 8'd255; thr_y = 8'd255; mode_abs = 1'b1;
        send(8'd255, 8'd0, 8'd0, 8'd255, 1'b0);
        thr_x = 8'd0; thr_y = 8'd0;
        send(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        wait_rec("t23_count", 6);
        chk_rec("t2_abs",     0, 3'b110);
        chk_rec("t2_signed",  1, 3'b000);
        chk_rec("t3_ext",     2, 3'b100);
        chk_rec("t3_zero",    3, 3'b000);
        chk_rec("t3_abs255",  4, 3'b110);
        chk_rec("t3_abszero", 5, 3'b110);
        rec.delete();
        sync_drive();

        // ---------------- back-pressure with toggling m_ready
        thr_x = 8'd33; thr_y = 8'd32; mode_abs = 1'b0;
        tgl_en = 1'b1;
        for (int i = 0; i < 8; i++) send(8'd0, 8'd0, t4v[i], t4v[i], 1'b0);
        wait_rec("t4_count", 8);
        for (int i = 0; i < 8; i++) chk_rec("t4", i, t4e[i]);
        rec.delete();
        tgl_en = 1'b0;
        rdy_level = 1'b1;
        repeat (2) sync_drive();

        // ---------------- frame counting (clear first to drop earlier edges)
        clear = 1'b1;
        @(negedge clock);
        chk("clr_s_ready0", 32'(bus.s_ready), 32'd0);
        sync_drive();
        clear = 1'b0;
        fd_cnt = 0;
        for (int i = 0; i < 5; i++) send(8'd0, 8'd0, t5v[i], t5v[i], i == 4);
        wait_rec("t5_count", 5);
        chk_rec("t5_last", 4, 3'b111);
        chk("t5_fd_cnt",      32'(fd_cnt),      32'd1);
        chk("t5_fd_val",      32'(fd_val),      32'd3);
        chk("t5_frame_edges", 32'(frame_edges), 32'd3);
        rec.delete();
        sync_drive();
        send(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        send(8'd0, 8'd0, 8'd40, 8'd40, 1'b1);
        wait_rec("t5b_count", 2);
        chk("t5b_fd_cnt",      32'(fd_cnt),      32'd2);
        chk("t5b_frame_edges", 32'(frame_edges), 32'd1);
        rec.delete();
        sync_drive();

        // ---------------- saturation: 9 edges into a 3-bit counter
        for (int i = 0; i < 9; i++) send(8'd0, 8'd0, 8'd40, 8'd40, i == 8);
        wait_rec("sat_count", 9);
        chk("sat_fd_cnt",      32'(fd_cnt),      32'd3);
        chk("sat_frame_edges", 32'(frame_edges), 32'd7);
        rec.delete();
        sync_drive();

        // ---------------- clear with two beats in flight
        send(8'd0, 8'd0, 8'd40, 8'd40, 1'b0);
        send(8'd0, 8'd0, 8'd40, 8'd40, 1'b0);
        wait_rec("t6_pre_count", 2);
        rec.delete();
        rdy_level = 1'b0;
        repeat (2) sync_drive();
        send(8'd0, 8'd0, 8'd40, 8'd40, 1'b0);
        send(8'd0, 8'd0, 8'd40, 8'd40, 1'b0);
        @(negedge clock);
        chk("t6_stalled_valid", 32'(bus.m_valid), 32'd1);
        sync_drive();
        clear = 1'b1;
        @(negedge clock);
        chk("t6_clr_s_ready", 32'(bus.s_ready), 32'd0);
        sync_drive();
        clear = 1'b0;
        @(negedge clock);
        chk("t6_m_valid",     32'(bus.m_valid), 32'd0);
        chk("t6_edges_kept",  32'(frame_edges), 32'd7);
        rdy_level = 1'b1;
        repeat (4) @(negedge clock);
        chk("t6_no_output",   32'(rec.size()), 32'd0);
        chk("t6_no_fd",       32'(fd_cnt),     32'd3);
        sync_drive();
        send(8'd0, 8'd0, 8'd40, 8'd40, 1'b1);
        wait_rec("t6_post_count", 1);
        chk("t6_count_zeroed", 32'(frame_edges), 32'd1);
        chk("t6_fd_cnt",       32'(fd_cnt),      32'd4);
        rec.delete();
        sync_drive();

        // ---------------- async reset during a stall
        rdy_level = 1'b0;
        repeat (2) sync_drive();
        send(8'd0, 8'd0, 8'd40, 8'd40, 1'b1);
        send(8'd0, 8'd0, 8'd40, 8'd40, 1'b1);
        @(negedge clock);
        chk("rs_pre_out", 32'({bus.m_valid, bus.m_thdx, bus.m_thdy, bus.m_last}), 32'hF);
        @(posedge clock);
        #3 nReset = 1'b0;
        #1;
        chk("rs_m_out",       32'({bus.m_valid, bus.m_thdx, bus.m_thdy, bus.m_last}), 32'd0);
        chk("rs_frame_edges", 32'(frame_edges), 32'd0);
        chk("rs_frame_done",  32'(frame_done),  32'd0);
        repeat (2) sync_drive();
        nReset = 1'b1;
        rdy_level = 1'b1;
        repeat (4) @(negedge clock);
        chk("rs_post_valid",  32'(bus.m_valid), 32'd0);
        chk("rs_post_rec",    32'(rec.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
